// File: rtl/fwd_hazard_scoreboard.sv
// rtl/fwd_hazard_scoreboard.sv - forwarding select and load-use stall unit for the integer pipeline
// Optional FWD_STATS_EN adds saturating stall_cnt / fwd_cnt outputs.
module fwd_hazard_scoreboard #(
   parameter  int NSRC  = 2,
   parameter  int DEPTH = 3,
   parameter  int REGW  = 5,
   localparam int SELW  = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [2:0]             id_type,
   input  logic [REGW-1:0]        id_rd,
   input  logic [NSRC*REGW-1:0]   id_rs,
   input  logic [NSRC-1:0]        id_rs_used,
   input  logic                   flush,
   output logic [NSRC*SELW-1:0]   fw_sel,
   output logic                   stall
`ifdef FWD_STATS_EN
   ,
   output logic [15:0]            stall_cnt,
   output logic [15:0]            fwd_cnt
`endif
);

   localparam logic [2:0] T_LOAD = 3'b000;
   localparam logic [2:0] T_S    = 3'b010;
   localparam logic [2:0] T_B    = 3'b111;

   logic                 ex_valid_q, ex_valid_d;
   logic [NSRC*REGW-1:0] ex_rs_q, ex_rs_d;
   logic [NSRC-1:0]      ex_used_q, ex_used_d;
   logic [REGW-1:0]      ex_rd_q, ex_rd_d;
   logic                 ex_wr_q, ex_wr_d;
   logic                 ex_load_q, ex_load_d;

   logic                 st_valid_q [1:DEPTH];
   logic [REGW-1:0]      st_rd_q    [1:DEPTH];
   logic                 st_wr_q    [1:DEPTH];

   logic                 rs_hit;
   logic                 ex_load_live;

   always_comb begin
      rs_hit = 1'b0;
      for (int s = 0; s < NSRC; s++) begin
         if (id_rs_used[s] && (id_rs[s*REGW +: REGW] == ex_rd_q)) begin
            rs_hit = 1'b1;
         end
      end
      ex_load_live = ex_valid_q && ex_load_q && ex_wr_q && (ex_rd_q != '0);
      stall        = id_valid && !flush && ex_load_live && rs_hit;

      // A stalled or flushed ID instruction leaves a bubble in EX.
      ex_valid_d = id_valid && !flush && !stall;
      ex_rs_d    = id_rs;
      ex_used_d  = id_rs_used;
      ex_rd_d    = id_rd;
      ex_wr_d    = (id_type != T_S) && (id_type != T_B);
      ex_load_d  = (id_type == T_LOAD);
   end

   // Scan from the oldest stage down so the nearest live match is written last.
   always_comb begin
      fw_sel = '0;
      for (int s = 0; s < NSRC; s++) begin
         for (int k = DEPTH; k >= 1; k--) begin
            if (ex_valid_q && ex_used_q[s] && st_valid_q[k] && st_wr_q[k] &&
                (st_rd_q[k] != '0) && (st_rd_q[k] == ex_rs_q[s*REGW +: REGW])) begin
               fw_sel[s*SELW +: SELW] = SELW'(k);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_rs_q    <= '0;
         ex_used_q  <= '0;
         ex_rd_q    <= '0;
         ex_wr_q    <= 1'b0;
         ex_load_q  <= 1'b0;
         for (int k = 1; k <= DEPTH; k++) begin
            st_valid_q[k] <= 1'b0;
            st_rd_q[k]    <= '0;
            st_wr_q[k]    <= 1'b0;
         end
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_rs_q       <= ex_rs_d;
         ex_used_q     <= ex_used_d;
         ex_rd_q       <= ex_rd_d;
         ex_wr_q       <= ex_wr_d;
         ex_load_q     <= ex_load_d;
         st_valid_q[1] <= ex_valid_q;
         st_rd_q[1]    <= ex_rd_q;
         st_wr_q[1]    <= ex_wr_q;
         for (int k = 2; k <= DEPTH; k++) begin
            st_valid_q[k] <= st_valid_q[k-1];
            st_rd_q[k]    <= st_rd_q[k-1];
            st_wr_q[k]    <= st_wr_q[k-1];
         end
      end
   end

`ifdef FWD_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] fwd_cnt_q, fwd_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if ((|fw_sel) && (fwd_cnt_q != 16'hFFFF)) begin
         fwd_cnt_d = fwd_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb/tb_fwd_hazard_scoreboard.sv - directed self-checking bench for fwd_hazard_scoreboard
module tb_fwd_hazard_scoreboard;

   localparam logic [2:0] T_R    = 3'b011;
   localparam logic [2:0] T_S    = 3'b010;
   localparam logic [2:0] T_B    = 3'b111;
   localparam logic [2:0] T_IL   = 3'b001;
   localparam logic [2:0] T_LOAD = 3'b000;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [2:0] id_type;
   logic [4:0] id_rd;
   logic [9:0] id_rs;
   logic [1:0] id_rs_used;
   logic       flush;
   logic [3:0] fw_sel;
   logic       stall;
`ifdef FWD_STATS_EN
   logic [15:0] stall_cnt;
   logic [15:0] fwd_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fwd_hazard_scoreboard #(.NSRC(2), .DEPTH(3), .REGW(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_type    (id_type),
      .id_rd      (id_rd),
      .id_rs      (id_rs),
      .id_rs_used (id_rs_used),
      .flush      (flush),
      .fw_sel     (fw_sel),
      .stall      (stall)
`ifdef FWD_STATS_EN
      ,
      .stall_cnt  (stall_cnt),
      .fwd_cnt    (fwd_cnt)
`endif
   );

   task automatic set_id(input logic v, input logic [2:0] t, input logic [4:0] rd,
                         input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
      id_valid   = v;
      id_type    = t;
      id_rd      = rd;
      id_rs      = {rs1, rs0};
      id_rs_used = used;
      #1;
   endtask

   task automatic idle();
      set_id(1'b0, T_R, 5'd0, 5'd0, 5'd0, 2'b00);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      flush = 1'b0;
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      flush = 1'b0;
      rst   = 1'b1;
      idle();
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_hi_stall got=%0b exp=0", stall); end
      total++; if (fw_sel !== 4'd0) begin bad++; $display("FAIL rst_hi_fw got=%0h exp=0", fw_sel); end
      step();
      step();
      rst = 1'b0;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_lo_stall got=%0b exp=0", stall); end
      total++; if (fw_sel !== 4'd0) begin bad++; $display("FAIL rst_lo_fw got=%0h exp=0", fw_sel); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_id(1'b1, T_R, 5'd5, 5'd1, 5'd2, 2'b11);
      step();
      set_id(1'b1, T_R, 5'd9, 5'd5, 5'd0, 2'b01);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%0b exp=0", stall); end
      step();
      idle();
      total++; if (fw_sel !== 4'b0001) begin bad++; $display("FAIL b2b_fw got=%0h exp=1", fw_sel); end
      step();
      total++; if (fw_sel !== 4'd0) begin bad++; $display("FAIL b2b_bubble_fw got=%0h exp=0", fw_sel); end
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1'b1, T_LOAD, 5'd7, 5'd1, 5'd0, 2'b01);
      step();
      set_id(1'b1, T_R, 5'd8, 5'd2, 5'd7, 2'b10);
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b exp=1", stall); end
      step();
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_once got=%0b exp=0", stall); end
      total++; if (fw_sel !== 4'd0) begin bad++; $display("FAIL lu_bubble_fw got=%0h exp=0", fw_sel); end
      step();
      idle();
      total++; if (fw_sel !== 4'b1000) begin bad++; $display("FAIL lu_fw got=%0h exp=8", fw_sel); end
   endtask

   task automatic test_priority();
      do_reset();
      set_id(1'b1, T_IL, 5'd3, 5'd0, 5'd0, 2'b00);
      step();
      set_id(1'b1, T_S, 5'd3, 5'd0, 5'd0, 2'b00);
      step();
      set_id(1'b1, T_R, 5'd3, 5'd0, 5'd0, 2'b00);
      step();
      set_id(1'b1, T_R, 5'd10, 5'd3, 5'd3, 2'b11);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL prio_stall got=%0b exp=0", stall); end
      step();
      idle();
      total++; if (fw_sel !== 4'b0101) begin bad++; $display("FAIL prio_near got=%0h exp=5", fw_sel); end

      do_reset();
      set_id(1'b1, T_IL, 5'd3, 5'd0, 5'd0, 2'b00);
      step();
      set_id(1'b1, T_S, 5'd3, 5'd0, 5'd0, 2'b00);
      step();
      set_id(1'b1, T_B, 5'd3, 5'd0, 5'd0, 2'b00);
      step();
      set_id(1'b1, T_R, 5'd10, 5'd3, 5'd3, 2'b11);
      step();
      idle();
      total++; if (fw_sel !== 4'b1111) begin bad++; $display("FAIL prio_nonwriters got=%0h exp=f", fw_sel); end
   endtask

   task automatic test_depth_edge();
      do_reset();
      set_id(1'b1, T_IL, 5'd6, 5'd0, 5'd0, 2'b00);
      step();
      idle();
      step();
      step();
      set_id(1'b1, T_R, 5'd0, 5'd6, 5'd0, 2'b01);
      step();
      idle();
      total++; if (fw_sel !== 4'b0011) begin bad++; $display("FAIL depth_last got=%0h exp=3", fw_sel); end

      do_reset();
      set_id(1'b1, T_IL, 5'd6, 5'd0, 5'd0, 2'b00);
      step();
      idle();
      step();
      step();
      step();
      set_id(1'b1, T_R, 5'd0, 5'd6, 5'd0, 2'b01);
      step();
      idle();
      total++; if (fw_sel !== 4'd0) begin bad++; $display("FAIL depth_dropped got=%0h exp=0", fw_sel); end
   endtask

   task automatic test_x0_unused();
      do_reset();
      set_id(1'b1, T_R, 5'd0, 5'd1, 5'd0, 2'b01);
      step();
      set_id(1'b1, T_R, 5'd9, 5'd0, 5'd0, 2'b11);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0_stall got=%0b exp=0", stall); end
      step();
      idle();
      total++; if (fw_sel !== 4'd0) begin bad++; $display("FAIL x0_fw got=%0h exp=0", fw_sel); end

      do_reset();
      set_id(1'b1, T_LOAD, 5'd0, 5'd1, 5'd0, 2'b01);
      step();
      set_id(1'b1, T_R, 5'd9, 5'd0, 5'd0, 2'b11);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0_load_stall got=%0b exp=0", stall); end

      do_reset();
      set_id(1'b1, T_LOAD, 5'd4, 5'd1, 5'd0, 2'b00);
      step();
      set_id(1'b1, T_R, 5'd9, 5'd4, 5'd4, 2'b00);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL unused_stall got=%0b exp=0", stall); end
      step();
      idle();
      step();
      total++; if (fw_sel !== 4'd0) begin bad++; $display("FAIL unused_fw got=%0h exp=0", fw_sel); end
   endtask

   task automatic test_flush();
      do_reset();
      set_id(1'b1, T_R, 5'd5, 5'd0, 5'd0, 2'b00);
      step();
      flush = 1'b1;
      set_id(1'b1, T_R, 5'd9, 5'd5, 5'd0, 2'b01);
      step();
      flush = 1'b0;
      idle();
      total++; if (fw_sel !== 4'd0) begin bad++; $display("FAIL flush_fw got=%0h exp=0", fw_sel); end

      do_reset();
      set_id(1'b1, T_LOAD, 5'd7, 5'd0, 5'd0, 2'b00);
      step();
      flush = 1'b1;
      set_id(1'b1, T_R, 5'd9, 5'd7, 5'd0, 2'b01);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0b exp=0", stall); end
      step();
      flush = 1'b0;
      idle();
      step();
      total++; if (fw_sel !== 4'd0) begin bad++; $display("FAIL flush_load_fw got=%0h exp=0", fw_sel); end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_id(1'b1, T_R, 5'd5, 5'd0, 5'd0, 2'b00);
      step();
      step();
      step();
      set_id(1'b1, T_LOAD, 5'd7, 5'd0, 5'd0, 2'b00);
      step();
      set_id(1'b1, T_R, 5'd9, 5'd5, 5'd7, 2'b11);
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL mid_pre_stall got=%0b exp=1", stall); end
      rst = 1'b1;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL mid_rst_stall got=%0b exp=0", stall); end
      total++; if (fw_sel !== 4'd0) begin bad++; $display("FAIL mid_rst_fw got=%0h exp=0", fw_sel); end
      step();
      rst = 1'b0;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL mid_post_stall got=%0b exp=0", stall); end
      step();
      idle();
      total++; if (fw_sel !== 4'd0) begin bad++; $display("FAIL mid_stale_fw got=%0h exp=0", fw_sel); end
   endtask

`ifdef FWD_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, T_LOAD, 5'd7, 5'd0, 5'd0, 2'b00);
         step();
         set_id(1'b1, T_R, 5'd0, 5'd0, 5'd7, 2'b10);
         step();
         step();
         idle();
         step();
         step();
         step();
         step();
      end
      for (int i = 0; i < 2; i++) begin
         set_id(1'b1, T_R, 5'd5, 5'd0, 5'd0, 2'b00);
         step();
         set_id(1'b1, T_R, 5'd0, 5'd5, 5'd0, 2'b01);
         step();
         idle();
         step();
         step();
         step();
         step();
      end
      total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stats_stall got=%0d exp=3", stall_cnt); end
      total++; if (fwd_cnt !== 16'd5) begin bad++; $display("FAIL stats_fwd got=%0d exp=5", fwd_cnt); end
      set_id(1'b1, T_R, 5'd5, 5'd5, 5'd0, 2'b01);
      repeat (65600) step();
      idle();
      step();
      step();
      total++; if (fwd_cnt !== 16'hFFFF) begin bad++; $display("FAIL stats_sat got=%0h exp=ffff", fwd_cnt); end
      total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stats_stall_hold got=%0d exp=3", stall_cnt); end
   endtask
`endif

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      idle();
      test_reset();
      test_back_to_back();
      test_load_use();
      test_priority();
      test_depth_edge();
      test_x0_unused();
      test_flush();
      test_reset_mid_stall();
`ifdef FWD_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_scoreboard.md
# fwd_hazard_scoreboard

Parametrised forwarding and load-use hazard unit for the integer pipeline. It holds its own shadow of the EX slot and of the DEPTH post-EX stages: destination register, write-enable and load flag for each. From these it produces a per-operand forwarding select for the instruction in EX, and a load-use stall for the instruction in ID. It sits beside the ID/EX pipeline registers and drives the EX operand muxes and the ID/IF hold logic.

## Interface
- NSRC, 2, number of source operands per instruction
- DEPTH, 3, number of post-EX stages tracked (stage 1 = EX/MEM, stage 2 = MEM/WB, ...)
- REGW, 5, register index width
- SELW (localparam), $clog2(DEPTH+1), forwarding select width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  an instruction is present in ID
- id_type  in  3  instruction type: R=011, S=010, B=111, J=100, U=101, I_jump=110, I_logic=001, I_load=000
- id_rd  in  REGW  destination of the ID instruction
- id_rs  in  NSRC*REGW  source registers of the ID instruction, operand s at [s*REGW +: REGW]
- id_rs_used  in  NSRC  operand s is actually read
- flush  in  1  squash the ID instruction (taken branch/jump)
- fw_sel  out  NSRC*SELW  per EX operand: 0 = register file, k = forward from stage k
- stall  out  1  load-use hazard; ID/IF must hold and EX receives a bubble

## Operation
- Writes-rd is true for R, U, J, I_jump, I_logic and I_load; it is false for S and B. An entry is "live" when valid, writes-rd and rd != 0.
- EX slot state: ex_valid, ex_rs[NSRC], ex_used[NSRC], ex_rd, ex_wr, ex_load.
- Stage state: entry k ∈ 1..DEPTH holds valid, rd, wr.
- Advance, every cycle:
  - entry[k] <= entry[k-1] for k ≥ 2.
  - entry[1] <= EX slot.
  - The EX slot loads from ID when stall=0, flush=0 and id_valid=1. Otherwise the EX slot becomes a bubble (ex_valid=0).
  - Flush has priority over stall. On flush the ID instruction is discarded, and the stall output still reflects the current state.
- Stall is combinational. It asserts when all of these hold:
  - id_valid=1 and flush=0;
  - ex_valid=1, ex_load=1, ex_wr=1 and ex_rd != 0;
  - some operand s has id_rs_used[s]=1 and id_rs[s]==ex_rd.
- Forwarding is combinational, per operand s:
  - fw_sel[s] = the smallest k with entry[k] live, ex_used[s]=1 and entry[k].rd==ex_rs[s].
  - fw_sel[s] = 0 if no k matches, or if ex_valid=0.
  - The nearest stage always wins when several stages match.
  - Both operands naming the same register receive the same select.
- A load's result is never forwarded from stage 1, because stall guarantees a load is in stage ≥ 2 before its consumer is in EX.
- Register 0 never forwards and never stalls.

## Timing
- Reset (asynchronous, immediate): all valid bits, the EX slot and all entries clear; fw_sel = 0 and stall = 0 while rst is high and after release.
- Latency from ID presentation to EX slot is one cycle. The EX slot enters stage 1 one cycle later. The entry is dropped after stage DEPTH.
- A load followed immediately by a dependent instruction produces exactly one stall cycle. On the next cycle the dependent instruction enters EX with fw_sel = 2.
- Stall never lasts more than one consecutive cycle for a given ID instruction.
- If rst asserts mid-stall, stall deasserts at once. The ID instruction is re-presented by upstream after reset.
- No combinational path runs from id_* inputs to fw_sel. fw_sel depends only on registered state.

## Configuration
- FWD_STATS_EN defined adds two outputs:
  - stall_cnt (out, 16): increments on every cycle with stall=1.
  - fwd_cnt (out, 16): increments on every cycle with any fw_sel != 0.
  - Both counters saturate at 16'hFFFF and reset to 0 on rst.
- FWD_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Back-to-back dependency:
  - Stimulus: R-type x5 <= ..., then an R-type reading x5 on operand 0 (NSRC=2, DEPTH=3).
  - Required: fw_sel operand 0 = 1 while the consumer is in EX; stall never asserts.
- Load-use:
  - Stimulus: I_load x7, then an add reading x7 on operand 1.
  - Required: stall=1 for exactly one cycle; then fw_sel operand 1 = 2; a bubble occupies stage 1.
- Priority and non-writers:
  - Stimulus: x3 written at stage 3 and stage 1, with an S-type carrying rd field 3 at stage 2; consumer reads x3 on both operands.
  - Required: fw_sel = {1,1}; the S-type is ignored.
- x0 and unused operands:
  - Stimulus: producer of x0 followed by a consumer of x0; separately, a load x4 followed by a consumer with id_rs=4 and id_rs_used=0.
  - Required: fw_sel = 0 and stall = 0 in both cases.
- Flush and reset:
  - Stimulus: flush while a dependent instruction is in ID; then assert rst with valid entries in all stages.
  - Required: the flushed instruction never reaches EX (fw_sel = 0 next cycle); after rst, all outputs are 0 and no stale forward occurs.
- FWD_STATS_EN builds:
  - Stimulus: 3 load-use pairs and 5 forwarded uses.
  - Required: stall_cnt = 3 and fwd_cnt = 5 (counting cycles); a forced counter at 16'hFFFF holds at 16'hFFFF.
